sseg_scan_decoder: RTL
======================

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning consecutive stable cycles before a digit sample is accepted (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning cycles without any accepted digit before the frame is abandoned.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port an, input, 4, meaning anode enables from the multiplexed display driver; active-low, one-hot-low when valid.
REQ-006 SHALL have port sseg, input, 7, meaning segment lines as {g,f,e,d,c,b,a}; active-low.
REQ-007 SHALL have port value, output, 16, meaning the last complete frame; digit k occupies value[4k+3:4k].
REQ-008 SHALL have port frame_valid, output, 1, meaning a one-cycle pulse when value updates.
REQ-009 SHALL have port seg_err, output, 1, meaning a one-cycle pulse when a settled pattern is not in the decode table.
REQ-010 SHALL have port timeout, output, 1, meaning a one-cycle pulse when a partial frame is abandoned.

Function
REQ-011 SHALL register an and sseg once on input; all decisions SHALL use the registered copies.
REQ-012 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-013 IDLE: if an is not one-hot-low, stay; else load the settle counter with 1, latch an/sseg as the candidate, go to SETTLE.
REQ-014 SETTLE: if an or sseg differs from the candidate, return to IDLE; else increment; on reaching SETTLE, accept the sample and go to HOLD.
REQ-015 HOLD: stay while an equals the candidate anode; on any change, go to IDLE in that same cycle, so no double capture per anode period.
REQ-016 The decode table SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 On acceptance of a table pattern, SHALL write the nibble into shadow slot k (an[k]=0) and set seen[k].
REQ-018 On acceptance of a non-table pattern, SHALL pulse seg_err the next cycle and leave shadow and seen unchanged.
REQ-019 When seen becomes 4'b1111, SHALL copy the shadow to value, pulse frame_valid, and clear seen, all in one cycle; latency from the accepting cycle is 1 clock.
REQ-020 A repeated digit before frame completion SHALL overwrite its shadow slot; the newest value wins.
REQ-021 The timeout counter SHALL clear on every acceptance; on reaching TIMEOUT with seen nonzero, SHALL clear seen and pulse timeout; with seen zero, no pulse.
REQ-022 If acceptance and timeout occur in the same cycle, acceptance SHALL win and the counter SHALL clear.
REQ-023 value SHALL be stable between frame_valid pulses.

Reset
REQ-024 On rst, SHALL set FSM=IDLE, value=16'h0000, frame_valid=0, seg_err=0, timeout=0, seen=0, shadow=0, and all counters=0.
REQ-025 rst asserted mid-SETTLE or mid-frame SHALL discard partial data; there SHALL be no frame_valid until four fresh digits are accepted after release.

Configuration
REQ-026 Macro SSEG_DP_EN SHALL control the decimal-point feature.
REQ-027 With SSEG_DP_EN defined: adds input dp (1, active-low) and output dp_out (4). dp SHALL be sampled and stability-checked with sseg, and dp_out[k] SHALL update atomically with value; dp_out SHALL reset to 0.
REQ-028 Without SSEG_DP_EN: neither port exists and behaviour is otherwise identical.

Structure
REQ-029 Package sseg_pkg SHALL hold the FSM state typedef, the 16-entry segment pattern constants, and the default SETTLE/TIMEOUT constants.
REQ-030 Sub-module sseg_pattern_decode SHALL be purely combinational: 7-bit pattern -> 4-bit nibble plus valid flag.

Verification
REQ-031 Scan digits 1,2,3,4 on an=1110,1101,1011,0111, 16 cycles each -> frame_valid pulses once, value=16'h4321.
REQ-032 Hold each digit for only 3 cycles with SETTLE=4 -> no acceptance, no frame_valid, no seg_err.
REQ-033 Settled sseg=7'b1111111 on an=1110 -> seg_err pulses once; seen[0] stays 0.
REQ-034 Scan digits 0 and 1 only, then an=1111 for 1024 cycles -> timeout pulses once; value stays 16'h0000.
REQ-035 Assert rst after three digits are accepted, then scan A,b,C,d -> frame_valid pulses once, value=16'hdCbA.
REQ-036 With SSEG_DP_EN, scan 8,8,8,8 with dp low on digit 2 only -> value=16'h8888, dp_out=4'b0100.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam int unsigned SETTLE_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic logic onehot_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) ||
           (a == 4'b1011) || (a == 4'b0111);
  endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// o_ok is low for any pattern outside the 16-entry table.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_nib,
  output logic       o_ok
);

  always_comb begin
    o_nib = 4'h0;
    o_ok  = 1'b1;
    unique case (1'b1)
      (i_pat == SEG_0): o_nib = 4'h0;
      (i_pat == SEG_1): o_nib = 4'h1;
      (i_pat == SEG_2): o_nib = 4'h2;
      (i_pat == SEG_3): o_nib = 4'h3;
      (i_pat == SEG_4): o_nib = 4'h4;
      (i_pat == SEG_5): o_nib = 4'h5;
      (i_pat == SEG_6): o_nib = 4'h6;
      (i_pat == SEG_7): o_nib = 4'h7;
      (i_pat == SEG_8): o_nib = 4'h8;
      (i_pat == SEG_9): o_nib = 4'h9;
      (i_pat == SEG_A): o_nib = 4'hA;
      (i_pat == SEG_B): o_nib = 4'hB;
      (i_pat == SEG_C): o_nib = 4'hC;
      (i_pat == SEG_D): o_nib = 4'hD;
      (i_pat == SEG_E): o_nib = 4'hE;
      (i_pat == SEG_F): o_nib = 4'hF;
      default:          o_ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers a 4-digit hex value by snooping a multiplexed 7-seg display.
// Define SSEG_DP_EN to add the decimal-point input dp and output dp_out.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int unsigned SETTLE  = SETTLE_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
`ifdef SSEG_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic FAST = (SETTLE == 1);

  state_t        r_state;
  logic [3:0]    r_an;
  logic [6:0]    r_sseg;
  logic [3:0]    r_cand_an;
  logic [6:0]    r_cand_seg;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_seen;
  logic [15:0]   r_shadow;
  logic [15:0]   r_value;
  logic          r_fv;
  logic          r_err;
  logic          r_to;

  logic          w_onehot;
  logic          w_same;
  logic          w_dp_same;
  logic          w_accept;
  logic          w_ok;
  logic          w_to_hit;
  logic [3:0]    w_slot;
  logic [3:0]    w_nib;
  logic [3:0]    w_seen_nxt;
  logic [15:0]   w_shadow_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= 4'hF;
      r_sseg <= 7'h7F;
    end else begin
      r_an   <= an;
      r_sseg <= sseg;
    end
  end

  sseg_pattern_decode u_dec (
    .i_pat (r_sseg),
    .o_nib (w_nib),
    .o_ok  (w_ok)
  );

  assign w_onehot = onehot_low(r_an);
  assign w_same   = (r_an == r_cand_an) &&
                    (r_sseg == r_cand_seg) && w_dp_same;
  // the IDLE capture cycle already counts as one stable cycle
  assign w_accept = (r_state == ST_IDLE && w_onehot && FAST) ||
                    (r_state == ST_SETTLE && w_same &&
                     r_cnt >= SET_LAST);
  assign w_slot     = ~r_an;
  assign w_seen_nxt = r_seen | w_slot;
  assign w_to_hit   = (r_tcnt == TO_LAST);

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int k = 0; k < 4; k++) begin
      if (w_slot[k]) w_shadow_nxt[4*k +: 4] = w_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cand_an  <= 4'h0;
      r_cand_seg <= 7'h0;
      r_cnt      <= 8'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_onehot) begin
            r_cand_an  <= r_an;
            r_cand_seg <= r_sseg;
            r_cnt      <= 8'd1;
            r_state    <= w_accept ? ST_HOLD : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!w_same) r_state <= ST_IDLE;
          else if (w_accept) r_state <= ST_HOLD;
          else r_cnt <= r_cnt + 8'd1;
        end
        ST_HOLD: begin
          if (r_an != r_cand_an) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt   <= '0;
      r_seen   <= 4'h0;
      r_shadow <= 16'h0;
      r_value  <= 16'h0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_fv  <= 1'b0;
      r_err <= 1'b0;
      r_to  <= 1'b0;
      if (w_accept) begin
        r_tcnt <= '0;
        if (!w_ok) begin
          r_err <= 1'b1;
        end else if (&w_seen_nxt) begin
          r_shadow <= w_shadow_nxt;
          r_value  <= w_shadow_nxt;
          r_seen   <= 4'h0;
          r_fv     <= 1'b1;
        end else begin
          r_shadow <= w_shadow_nxt;
          r_seen   <= w_seen_nxt;
        end
      end else if (w_to_hit) begin
        r_tcnt <= '0;
        if (|r_seen) begin
          r_seen <= 4'h0;
          r_to   <= 1'b1;
        end
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

`ifdef SSEG_DP_EN
  logic       r_dp;
  logic       r_cand_dp;
  logic [3:0] r_dp_sh;
  logic [3:0] r_dp_out;
  logic [3:0] w_dp_sh_nxt;

  assign w_dp_same   = (r_dp == r_cand_dp);
  assign w_dp_sh_nxt = (r_dp_sh & r_an) | (w_slot & {4{~r_dp}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp      <= 1'b1;
      r_cand_dp <= 1'b1;
      r_dp_sh   <= 4'h0;
      r_dp_out  <= 4'h0;
    end else begin
      r_dp <= dp;
      if (r_state == ST_IDLE && w_onehot) r_cand_dp <= r_dp;
      if (w_accept && w_ok) begin
        r_dp_sh <= w_dp_sh_nxt;
        if (&w_seen_nxt) r_dp_out <= w_dp_sh_nxt;
      end
    end
  end

  assign dp_out = r_dp_out;
`else
  assign w_dp_same = 1'b1;
`endif

  assign value       = r_value;
  assign frame_valid = r_fv;
  assign seg_err     = r_err;
  assign timeout     = r_to;

endmodule
